data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a fixed-latency request/acknowledge handshake.
// The CPU is stalled until the access has finished its wait cycles; completion is a one-cycle ack.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_read_i,
    input  logic        req_write_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mem_we;
    logic            load_en;
    logic            stall_raw;
    logic            req_valid;
    logic            req_err;

    logic [31:0]     mem_q [DEPTH_WORDS];

    assign req_valid = req_read_i | req_write_i;
    // Misaligned, beyond the array, or both read and write asserted.
    assign req_err   = (req_addr_i[1:0] != 2'b00) | (|req_addr_i[31:AW+2]) |
                       (req_read_i & req_write_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        load_en   = 1'b0;
        stall_raw = 1'b0;
        ack_o     = 1'b0;
        err_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_raw = req_valid;
                if (req_valid) begin
                    idx_d   = req_addr_i[AW+1:2];
                    wdata_d = req_wdata_i;
                    rd_d    = req_read_i;
                    wr_d    = req_write_i;
                    err_d   = req_err;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                stall_raw = 1'b1;
                if (cnt_q == 4'd0) begin
                    mem_we  = wr_q & ~err_q;
                    load_en = rd_q & ~err_q;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                ack_o   = 1'b1;
                err_o   = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        stall_o = stall_raw & rst_i;
        rdata_d = load_en ? mem_q[idx_q] : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; an access aborted by reset never reaches StWait with cnt 0.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: cycle-count reference model checked every cycle,
// plus directed accesses with hand-computed latency, error and data expectations.
module tb_data_mem_responder;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    logic        clk;
    logic        rst_n;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_read;
    logic        req_write;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_read_i (req_read),
        .req_write_i(req_write),
        .stall_o    (stall),
        .ack_o      (ack),
        .err_o      (err),
        .rdata_o    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an accepted request occupies LAT+2 cycles counted from its first cycle.
    bit          m_busy  = 1'b0;
    int          m_start = 0;
    logic [7:0]  m_idx   = '0;
    logic [31:0] m_wdata = '0;
    bit          m_rd    = 1'b0;
    bit          m_wr    = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_rdata = 32'h0;
        end else if (m_busy) begin
            if (cyc - m_start == LAT && !m_err) begin
                if (m_wr) m_mem[m_idx] = m_wdata;
                if (m_rd) m_rdata = m_mem[m_idx];
            end
            if (cyc - m_start == LAT + 1) m_busy = 1'b0;
        end else if (req_read || req_write) begin
            m_busy  = 1'b1;
            m_start = cyc;
            m_idx   = req_addr[9:2];
            m_wdata = req_wdata;
            m_rd    = req_read;
            m_wr    = req_write;
            m_err   = (req_addr[1:0] != 2'b00) || (req_addr >= LIMIT) || (req_read && req_write);
        end
    end

    always @(negedge clk) begin
        bit e_stall, e_ack, e_err;
        int k;
        e_stall = 1'b0;
        e_ack   = 1'b0;
        e_err   = 1'b0;
        if (rst_n) begin
            if (!m_busy) begin
                e_stall = req_read || req_write;
            end else begin
                k       = cyc - m_start;
                e_stall = (k <= LAT);
                e_ack   = (k == LAT + 1);
                e_err   = e_ack && m_err;
            end
        end
        chk("model_stall", 32'(stall), 32'(e_stall));
        chk("model_ack",   32'(ack),   32'(e_ack));
        chk("model_err",   32'(err),   32'(e_err));
        chk("model_rdata", rdata, m_rdata);
    end

    task automatic wait_ack(input int start, output int lat, output logic e, output logic [31:0] q);
        bit got;
        got = 1'b0;
        lat = -1;
        e   = 1'b0;
        q   = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1;
                lat = cyc - start;
                e   = err;
                q   = rdata;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack, want ack within 20 cycles (start %0d)", start);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r,
                          input logic w, output int lat, output logic e, output logic [31:0] q);
        int start;
        req_addr  = a;
        req_wdata = d;
        req_read  = r;
        req_write = w;
        start     = cyc;
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        wait_ack(start, lat, e, q);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        e;
        logic [31:0] q;
        int          start;
        int          acks;

        rst_n     = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_read  = 1'b1;
        req_write = 1'b0;
        #1 rst_n  = 1'b0;

        #11;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_ack",   32'(ack),   32'h0);
        chk("reset_err",   32'(err),   32'h0);
        chk("reset_rdata", rdata,      32'h0);
        req_read = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        access(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, lat, e, q);
        chk("store_lat", 32'(lat), 32'd4);
        chk("store_err", 32'(e),   32'h0);

        access(32'h10, 32'h0, 1'b1, 1'b0, lat, e, q);
        chk("load_lat",  32'(lat), 32'd4);
        chk("load_err",  32'(e),   32'h0);
        chk("load_data", q,        32'hDEADBEEF);

        access(32'h12, 32'h0, 1'b1, 1'b0, lat, e, q);
        chk("misalign_err",  32'(e), 32'h1);
        chk("misalign_data", q,      32'hDEADBEEF);

        access(32'h400, 32'h0, 1'b1, 1'b0, lat, e, q);
        chk("range_lat",  32'(lat), 32'd4);
        chk("range_err",  32'(e),   32'h1);
        chk("range_data", q,        32'hDEADBEEF);

        access(32'h10, 32'h12345678, 1'b1, 1'b1, lat, e, q);
        chk("both_err",  32'(e), 32'h1);
        chk("both_data", q,      32'hDEADBEEF);
        access(32'h10, 32'h0, 1'b1, 1'b0, lat, e, q);
        chk("after_both_data", q, 32'hDEADBEEF);

        // Reset pulse inside the second wait cycle of a store.
        req_addr  = 32'h10;
        req_wdata = 32'h0BADF00D;
        req_write = 1'b1;
        @(posedge clk);
        #1 req_write = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'h0);
        @(posedge clk);
        #1;
        access(32'h10, 32'h0, 1'b1, 1'b0, lat, e, q);
        chk("abort_data", q, 32'hDEADBEEF);

        access(32'h20, 32'h11111111, 1'b0, 1'b1, lat, e, q);
        chk("store20_err", 32'(e), 32'h0);

        // Address changes mid-access while the read request stays high.
        req_addr = 32'h10;
        req_read = 1'b1;
        start    = cyc;
        @(posedge clk);
        #1 req_addr = 32'h20;
        wait_ack(start, lat, e, q);
        chk("hold_lat",        32'(lat),   32'd4);
        chk("hold_data",       q,          32'hDEADBEEF);
        chk("hold_resp_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        chk("hold_idle_stall", 32'(stall), 32'h1);
        start = cyc;
        @(posedge clk);
        #1 req_read = 1'b0;
        wait_ack(start, lat, e, q);
        chk("second_lat",  32'(lat), 32'd4);
        chk("second_data", q,        32'h11111111);
        @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
